fifo2lane_l2: RTL and testbench

- Dual-lane buffering stage directly downstream of the L2 1:2 demux.
- Captures the two demux outputs (valid + 8-bit data per lane) into two independent FIFOs.
- Downstream logic drains each lane through its own pop interface.
- Per-lane status flags are provided for flow control, plus sticky overflow/underflow error flags for debug.

---
 rtl/fifo2lane_l2_pkg.sv | 27 ++
 rtl/fifo_lane_l2.sv | 118 +++++++++++
 rtl/fifo2lane_l2.sv | 61 ++++++
 tb/tb_fifo2lane_l2.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo2lane_l2_pkg.sv
// Shared sizing constants for the dual-lane L2 demux buffering stage.
package fifo2lane_l2_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned ADDR_W    = 2;
    localparam int unsigned CNT_W     = ADDR_W + 1;
    localparam int unsigned AF_THRESH = 3;
    localparam int unsigned AE_THRESH = 1;

    // Occupancy after one cycle of accepted push/pop activity.
    function automatic logic [CNT_W-1:0] count_next(
        input logic [CNT_W-1:0] count,
        input logic             push_ok,
        input logic             pop_ok
    );
        logic [CNT_W-1:0] result;
        result = count;
        case ({push_ok, pop_ok})
            2'b10:   result = count + CNT_W'(1);
            2'b01:   result = count - CNT_W'(1);
            default: result = count;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/fifo_lane_l2.sv
// Single-lane FIFO: push/pop, registered read data, registered flags, sticky error.
module fifo_lane_l2
    import fifo2lane_l2_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              error
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              valid_out_q, valid_out_d;
    logic              error_q, error_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              almost_full_q, almost_full_d;
    logic              almost_empty_q, almost_empty_d;

    logic              pop_ok;
    logic              push_ok;

    // Accept logic, pointer/count update, read capture and post-update flags.
    always_comb begin
        pop_ok         = 1'b0;
        push_ok        = 1'b0;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        data_out_d     = data_out_q;
        valid_out_d    = 1'b0;
        error_d        = error_q;
        empty_d        = empty_q;
        full_d         = full_q;
        almost_full_d  = almost_full_q;
        almost_empty_d = almost_empty_q;

        // A pop frees a slot when full, so the push can reuse it the same cycle.
        pop_ok  = pop && !empty_q;
        push_ok = push && (!full_q || pop_ok);

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d    = rd_ptr_q + ADDR_W'(1);
            data_out_d  = mem_q[rd_ptr_q];
            valid_out_d = 1'b1;
        end

        count_d = count_next(count_q, push_ok, pop_ok);

        // Overflow drops the word; underflow (including empty push+pop) is ignored.
        if ((push && full_q && !pop_ok) || (pop && empty_q)) begin
            error_d = 1'b1;
        end

        empty_d        = (count_d == CNT_W'(0));
        full_d         = (count_d == CNT_W'(DEPTH));
        almost_full_d  = (count_d >= CNT_W'(AF_THRESH));
        almost_empty_d = (count_d <= CNT_W'(AE_THRESH));
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            data_out_q     <= '0;
            valid_out_q    <= 1'b0;
            error_q        <= 1'b0;
            empty_q        <= 1'b1;
            full_q         <= 1'b0;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            data_out_q     <= data_out_d;
            valid_out_q    <= valid_out_d;
            error_q        <= error_d;
            empty_q        <= empty_d;
            full_q         <= full_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
        end
    end

    // Storage array; contents are don't-care after reset so it is not cleared.
    always_ff @(posedge clk) begin
        if (push_ok && !reset) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign data_out     = data_out_q;
    assign valid_out    = valid_out_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign error        = error_q;

endmodule

// File: rtl/fifo2lane_l2.sv
// Dual-lane buffer behind the L2 1:2 demux: two independent lane FIFOs.
module fifo2lane_l2
    import fifo2lane_l2_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in0,
    input  logic              valid_in1,
    input  logic [DATA_W-1:0] data_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic              pop0,
    input  logic              pop1,
    output logic [DATA_W-1:0] data_out0,
    output logic [DATA_W-1:0] data_out1,
    output logic              valid_out0,
    output logic              valid_out1,
    output logic              empty0,
    output logic              empty1,
    output logic              full0,
    output logic              full1,
    output logic              almost_full0,
    output logic              almost_full1,
    output logic              almost_empty0,
    output logic              almost_empty1,
    output logic              error0,
    output logic              error1
);

    // Lane 0 buffer (demux output 0).
    fifo_lane_l2 u_lane0 (
        .clk          (clk),
        .reset        (reset),
        .push         (valid_in0),
        .push_data    (data_in0),
        .pop          (pop0),
        .data_out     (data_out0),
        .valid_out    (valid_out0),
        .empty        (empty0),
        .full         (full0),
        .almost_full  (almost_full0),
        .almost_empty (almost_empty0),
        .error        (error0)
    );

    // Lane 1 buffer (demux output 1).
    fifo_lane_l2 u_lane1 (
        .clk          (clk),
        .reset        (reset),
        .push         (valid_in1),
        .push_data    (data_in1),
        .pop          (pop1),
        .data_out     (data_out1),
        .valid_out    (valid_out1),
        .empty        (empty1),
        .full         (full1),
        .almost_full  (almost_full1),
        .almost_empty (almost_empty1),
        .error        (error1)
    );

endmodule

// File: tb/tb_fifo2lane_l2.sv
// Directed bench for fifo2lane_l2.
module tb_fifo2lane_l2;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_in0, valid_in1;
    logic [7:0] data_in0, data_in1;
    logic       pop0, pop1;
    logic [7:0] data_out0, data_out1;
    logic       valid_out0, valid_out1;
    logic       empty0, empty1, full0, full1;
    logic       almost_full0, almost_full1, almost_empty0, almost_empty1;
    logic       error0, error1;

    int n_checks = 0;
    int n_pass   = 0;

    fifo2lane_l2 dut (
        .clk           (clk),
        .reset         (reset),
        .valid_in0     (valid_in0),
        .valid_in1     (valid_in1),
        .data_in0      (data_in0),
        .data_in1      (data_in1),
        .pop0          (pop0),
        .pop1          (pop1),
        .data_out0     (data_out0),
        .data_out1     (data_out1),
        .valid_out0    (valid_out0),
        .valid_out1    (valid_out1),
        .empty0        (empty0),
        .empty1        (empty1),
        .full0         (full0),
        .full1         (full1),
        .almost_full0  (almost_full0),
        .almost_full1  (almost_full1),
        .almost_empty0 (almost_empty0),
        .almost_empty1 (almost_empty1),
        .error0        (error0),
        .error1        (error1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    initial begin
        logic [7:0] exp_d0, exp_d1;
        logic       exp_v0, exp_v1;
        logic       pu0, po0, pu1, po1;
        int         pre0, pre1;

        reset = 1'b1; valid_in0 = 1'b1; data_in0 = 8'hAA;
        valid_in1 = 1'b0; data_in1 = 8'h00; pop0 = 1'b0; pop1 = 1'b0;

        // Reset held two cycles with a push pending.
        step(); step();
        chk("rst_empty0", {7'b0, empty0}, 8'd1);
        chk("rst_empty1", {7'b0, empty1}, 8'd1);
        chk("rst_full0", {7'b0, full0}, 8'd0);
        chk("rst_af0", {7'b0, almost_full0}, 8'd0);
        chk("rst_ae0", {7'b0, almost_empty0}, 8'd1);
        chk("rst_err0", {7'b0, error0}, 8'd0);
        chk("rst_err1", {7'b0, error1}, 8'd0);
        chk("rst_vout0", {7'b0, valid_out0}, 8'd0);
        chk("rst_vout1", {7'b0, valid_out1}, 8'd0);
        chk("rst_dout0", data_out0, 8'h00);

        // Release; idle cycle must leave lane 0 empty.
        reset = 1'b0; valid_in0 = 1'b0;
        step();
        chk("post_rst_empty0", {7'b0, empty0}, 8'd1);

        // Lane 0: push 11,22,33.
        valid_in0 = 1'b1; data_in0 = 8'h11; step();
        chk("p1_empty0", {7'b0, empty0}, 8'd0);
        chk("p1_ae0", {7'b0, almost_empty0}, 8'd1);
        data_in0 = 8'h22; step();
        chk("p2_ae0", {7'b0, almost_empty0}, 8'd0);
        chk("p2_af0", {7'b0, almost_full0}, 8'd0);
        data_in0 = 8'h33; step();
        chk("p3_af0", {7'b0, almost_full0}, 8'd1);
        chk("p3_full0", {7'b0, full0}, 8'd0);

        // Lane 0: pop three times.
        valid_in0 = 1'b0; pop0 = 1'b1; step();
        chk("q1_v0", {7'b0, valid_out0}, 8'd1);
        chk("q1_d0", data_out0, 8'h11);
        chk("q1_af0", {7'b0, almost_full0}, 8'd0);
        step();
        chk("q2_d0", data_out0, 8'h22);
        step();
        chk("q3_v0", {7'b0, valid_out0}, 8'd1);
        chk("q3_d0", data_out0, 8'h33);
        chk("q3_empty0", {7'b0, empty0}, 8'd1);
        pop0 = 1'b0; step();
        chk("idle_v0", {7'b0, valid_out0}, 8'd0);
        chk("idle_hold_d0", data_out0, 8'h33);
        chk("idle_err0", {7'b0, error0}, 8'd0);

        // Lane 1: fill A0..A3 then overflow with FF.
        valid_in1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_in1 = 8'hA0 + 8'(i);
            step();
        end
        chk("fill_full1", {7'b0, full1}, 8'd1);
        chk("fill_af1", {7'b0, almost_full1}, 8'd1);
        chk("fill_err1", {7'b0, error1}, 8'd0);
        data_in1 = 8'hFF; step();
        chk("ovf_full1", {7'b0, full1}, 8'd1);
        chk("ovf_err1", {7'b0, error1}, 8'd1);
        valid_in1 = 1'b0; pop1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("drain1_v", {7'b0, valid_out1}, 8'd1);
            chk("drain1_d", data_out1, 8'hA0 + 8'(i));
        end
        chk("drain1_empty", {7'b0, empty1}, 8'd1);
        pop1 = 1'b0; step();
        chk("drain1_noff", {7'b0, valid_out1}, 8'd0);

        // Lane 0: fill 01..04, then push 55 with pop while full.
        valid_in0 = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            data_in0 = 8'(i);
            step();
        end
        chk("fill_full0", {7'b0, full0}, 8'd1);
        data_in0 = 8'h55; pop0 = 1'b1; step();
        chk("fpp_v0", {7'b0, valid_out0}, 8'd1);
        chk("fpp_d0", data_out0, 8'h01);
        chk("fpp_full0", {7'b0, full0}, 8'd1);
        chk("fpp_err0", {7'b0, error0}, 8'd0);
        valid_in0 = 1'b0;
        step(); chk("fd_d0a", data_out0, 8'h02);
        step(); chk("fd_d0b", data_out0, 8'h03);
        step(); chk("fd_d0c", data_out0, 8'h04);
        step(); chk("fd_d0d", data_out0, 8'h55);
        chk("fd_empty0", {7'b0, empty0}, 8'd1);
        chk("fd_err0", {7'b0, error0}, 8'd0);

        // Lane 0 empty: pop with simultaneous push of 77.
        valid_in0 = 1'b1; data_in0 = 8'h77; step();
        chk("epp_err0", {7'b0, error0}, 8'd1);
        chk("epp_v0", {7'b0, valid_out0}, 8'd0);
        chk("epp_empty0", {7'b0, empty0}, 8'd0);
        chk("epp_ae0", {7'b0, almost_empty0}, 8'd1);
        valid_in0 = 1'b0; step();
        chk("epp_pop_v0", {7'b0, valid_out0}, 8'd1);
        chk("epp_pop_d0", data_out0, 8'h77);
        chk("epp_pop_empty0", {7'b0, empty0}, 8'd1);
        pop0 = 1'b0; step();

        // Interleaved traffic on both lanes, checked against queue models.
        for (int i = 0; i < 12; i++) begin
            pu0 = 1'b1;           po0 = (i % 2) == 1;
            pu1 = (i % 3) != 2;   po1 = (i % 2) == 0;
            valid_in0 = pu0; data_in0 = 8'h80 + 8'(i); pop0 = po0;
            valid_in1 = pu1; data_in1 = 8'hC0 + 8'(i); pop1 = po1;
            pre0 = q0.size(); pre1 = q1.size();
            exp_v0 = po0 && pre0 > 0;
            exp_v1 = po1 && pre1 > 0;
            exp_d0 = 8'h00; exp_d1 = 8'h00;
            if (exp_v0) exp_d0 = q0.pop_front();
            if (exp_v1) exp_d1 = q1.pop_front();
            if (pu0 && (pre0 < 4 || exp_v0)) q0.push_back(data_in0);
            if (pu1 && (pre1 < 4 || exp_v1)) q1.push_back(data_in1);
            step();
            chk("il_v0", {7'b0, valid_out0}, {7'b0, exp_v0});
            chk("il_v1", {7'b0, valid_out1}, {7'b0, exp_v1});
            if (exp_v0) chk("il_d0", data_out0, exp_d0);
            if (exp_v1) chk("il_d1", data_out1, exp_d1);
            chk("il_empty0", {7'b0, empty0}, {7'b0, q0.size() == 0});
            chk("il_full1", {7'b0, full1}, {7'b0, q1.size() == 4});
        end

        // Mid-stream reset with traffic still asserted.
        reset = 1'b1; pop0 = 1'b1; pop1 = 1'b1; step();
        chk("mrst_empty0", {7'b0, empty0}, 8'd1);
        chk("mrst_empty1", {7'b0, empty1}, 8'd1);
        chk("mrst_full0", {7'b0, full0}, 8'd0);
        chk("mrst_af0", {7'b0, almost_full0}, 8'd0);
        chk("mrst_v0", {7'b0, valid_out0}, 8'd0);
        chk("mrst_err0", {7'b0, error0}, 8'd0);
        chk("mrst_err1", {7'b0, error1}, 8'd0);

        // After release, popping an emptied lane underflows.
        reset = 1'b0; valid_in0 = 1'b0; valid_in1 = 1'b0; pop1 = 1'b0; step();
        chk("post_mrst_v0", {7'b0, valid_out0}, 8'd0);
        chk("post_mrst_err0", {7'b0, error0}, 8'd1);
        chk("post_mrst_err1", {7'b0, error1}, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
